// File: rtl/regfile_sb.sv
// Parametrised register file with optional write-to-read bypass and a
// per-register pending-write scoreboard for decode-stage hazard detection.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREAD*$clog2(NREGS)-1:0] readreg,
    output logic [NREAD*XLEN-1:0]  readdata,
    output logic [NREAD-1:0]       hazard,
    input  logic [$clog2(NREGS)-1:0] writereg,
    input  logic [XLEN-1:0]        writedata,
    input  logic                   regwrite,
    input  logic                   issue_valid,
    input  logic [$clog2(NREGS)-1:0] issue_rd,
    output logic                   busy
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_next;
    logic             wr_en;

    assign wr_en = regwrite && (writereg != '0);

    // Clear first, then set: a new producer supersedes the retiring one.
    always_comb begin
        pending_next = pending;
        if (regwrite)
            pending_next[writereg] = 1'b0;
        if (issue_valid && (issue_rd != '0))
            pending_next[issue_rd] = 1'b1;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++)
                regs[r] <= '0;
            pending <= '0;
        end else begin
            if (wr_en)
                regs[writereg] <= writedata;
            pending <= pending_next;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_port
        logic [AW-1:0] ra;
        logic          fwd;

        assign ra  = readreg[i*AW +: AW];
        assign fwd = (BYPASS != 0) && wr_en && (writereg == ra);

        assign readdata[i*XLEN +: XLEN] = (ra == '0) ? '0 :
                                          fwd        ? writedata : regs[ra];
        assign hazard[i] = (ra != '0) && pending[ra] && !fwd;
    end

    assign busy = |pending;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one instance with bypass, one without,
// both fed the same stimulus.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [2*AW-1:0] readreg;
    logic [AW-1:0]   writereg;
    logic [XLEN-1:0] writedata;
    logic            regwrite;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;

    logic [2*XLEN-1:0] rd_b, rd_n;
    logic [1:0]        hz_b, hz_n;
    logic              busy_b, busy_n;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(XLEN), .NREGS(32), .NREAD(2), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .readreg(readreg), .readdata(rd_b), .hazard(hz_b),
        .writereg(writereg), .writedata(writedata), .regwrite(regwrite),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .busy(busy_b)
    );

    regfile_sb #(.XLEN(XLEN), .NREGS(32), .NREAD(2), .BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .readreg(readreg), .readdata(rd_n), .hazard(hz_n),
        .writereg(writereg), .writedata(writedata), .regwrite(regwrite),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .busy(busy_n)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        regwrite    = 1'b0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        writereg    = '0;
        writedata   = '0;
    endtask

    task automatic set_read(input logic [AW-1:0] p1, input logic [AW-1:0] p0);
        readreg = {p1, p0};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_read(5'd20, 5'd10);
        regwrite = 1'b1; writereg = 5'd10; writedata = 32'd5;
        tick();
        rst = 1'b0;
        idle();
        #1;
        checks++;
        if (rd_b !== 64'd0) begin errors++; $display("FAIL reset_rd_b: got %h exp 0", rd_b); end
        checks++;
        if (rd_n !== 64'd0) begin errors++; $display("FAIL reset_rd_n: got %h exp 0", rd_n); end
        checks++;
        if (hz_b !== 2'b00 || hz_n !== 2'b00) begin errors++; $display("FAIL reset_hazard: got %b/%b exp 00", hz_b, hz_n); end
        checks++;
        if (busy_b !== 1'b0 || busy_n !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b/%b exp 0", busy_b, busy_n); end
        tick();
        checks++;
        if (rd_b[31:0] !== 32'd0) begin errors++; $display("FAIL reset_reg10: got %0d exp 0", rd_b[31:0]); end
    endtask

    task automatic test_write_read();
        regwrite = 1'b1; writereg = 5'd15; writedata = 32'd78894131;
        tick();
        idle();
        set_read(5'd15, 5'd15);
        #1;
        checks++;
        if (rd_b !== {2{32'd78894131}}) begin errors++; $display("FAIL wr15_b: got %h exp %h", rd_b, {2{32'd78894131}}); end
        checks++;
        if (rd_n !== {2{32'd78894131}}) begin errors++; $display("FAIL wr15_n: got %h exp %h", rd_n, {2{32'd78894131}}); end
        set_read(5'd15, 5'd0);
        regwrite = 1'b1; writereg = 5'd0; writedata = 32'hDEADBEEF;
        #1;
        checks++;
        if (rd_b[31:0] !== 32'd0) begin errors++; $display("FAIL x0_same_cycle: got %h exp 0", rd_b[31:0]); end
        tick();
        idle();
        #1;
        checks++;
        if (rd_b[31:0] !== 32'd0 || rd_n[31:0] !== 32'd0) begin errors++; $display("FAIL x0_after: got %h/%h exp 0", rd_b[31:0], rd_n[31:0]); end
    endtask

    task automatic test_bypass();
        regwrite = 1'b1; writereg = 5'd25; writedata = 32'd1;
        tick();
        set_read(5'd25, 5'd15);
        regwrite = 1'b1; writereg = 5'd25; writedata = 32'd98765;
        #1;
        checks++;
        if (rd_b[63:32] !== 32'd98765) begin errors++; $display("FAIL bypass_on: got %0d exp 98765", rd_b[63:32]); end
        checks++;
        if (rd_n[63:32] !== 32'd1) begin errors++; $display("FAIL bypass_off_same: got %0d exp 1", rd_n[63:32]); end
        checks++;
        if (rd_b[31:0] !== 32'd78894131) begin errors++; $display("FAIL bypass_other_port: got %0d exp 78894131", rd_b[31:0]); end
        tick();
        idle();
        #1;
        checks++;
        if (rd_n[63:32] !== 32'd98765) begin errors++; $display("FAIL bypass_off_next: got %0d exp 98765", rd_n[63:32]); end
    endtask

    task automatic test_scoreboard();
        issue_valid = 1'b1; issue_rd = 5'd7;
        set_read(5'd7, 5'd7);
        #1;
        checks++;
        if (busy_b !== 1'b0) begin errors++; $display("FAIL sb_before_edge: busy %b exp 0", busy_b); end
        tick();
        idle();
        #1;
        checks++;
        if (hz_b !== 2'b11 || hz_n !== 2'b11) begin errors++; $display("FAIL sb_hazard: got %b/%b exp 11", hz_b, hz_n); end
        checks++;
        if (busy_b !== 1'b1 || busy_n !== 1'b1) begin errors++; $display("FAIL sb_busy: got %b/%b exp 1", busy_b, busy_n); end
        regwrite = 1'b1; writereg = 5'd7; writedata = 32'h77;
        #1;
        checks++;
        if (hz_b !== 2'b00) begin errors++; $display("FAIL sb_wb_mask: got %b exp 00", hz_b); end
        checks++;
        if (hz_n !== 2'b11) begin errors++; $display("FAIL sb_wb_nomask: got %b exp 11", hz_n); end
        checks++;
        if (busy_b !== 1'b1) begin errors++; $display("FAIL sb_busy_wb_cycle: got %b exp 1", busy_b); end
        tick();
        idle();
        #1;
        checks++;
        if (busy_b !== 1'b0 || busy_n !== 1'b0 || hz_b !== 2'b00 || hz_n !== 2'b00) begin
            errors++; $display("FAIL sb_cleared: busy %b/%b hazard %b/%b exp 0", busy_b, busy_n, hz_b, hz_n);
        end
        checks++;
        if (rd_n !== {2{32'h77}}) begin errors++; $display("FAIL sb_data: got %h exp %h", rd_n, {2{32'h77}}); end
    endtask

    task automatic test_simultaneous();
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        regwrite = 1'b1; writereg = 5'd7; writedata = 32'h1234;
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        idle();
        set_read(5'd7, 5'd7);
        #1;
        checks++;
        if (busy_b !== 1'b1 || hz_b !== 2'b11 || hz_n !== 2'b11) begin
            errors++; $display("FAIL simul_pending: busy %b hazard %b/%b exp 1/11", busy_b, hz_b, hz_n);
        end
        checks++;
        if (rd_b !== {2{32'h1234}}) begin errors++; $display("FAIL simul_data: got %h exp %h", rd_b, {2{32'h1234}}); end
        issue_valid = 1'b1; issue_rd = 5'd0;
        tick();
        idle();
        #1;
        checks++;
        if (busy_b !== 1'b1) begin errors++; $display("FAIL issue_x0_busy: got %b exp 1", busy_b); end
        regwrite = 1'b1; writereg = 5'd7; writedata = 32'h55;
        tick();
        issue_valid = 1'b1; issue_rd = 5'd0; regwrite = 1'b0;
        tick();
        idle();
        set_read(5'd0, 5'd0);
        #1;
        checks++;
        if (busy_b !== 1'b0 || hz_b !== 2'b00) begin errors++; $display("FAIL issue_x0_idle: busy %b hazard %b exp 0/00", busy_b, hz_b); end
    endtask

    task automatic test_mid_reset();
        for (int r = 3; r <= 5; r++) begin
            issue_valid = 1'b1; issue_rd = AW'(r);
            tick();
        end
        idle();
        set_read(5'd4, 5'd3);
        #1;
        checks++;
        if (hz_b !== 2'b11 || busy_b !== 1'b1) begin errors++; $display("FAIL pend345: hazard %b busy %b exp 11/1", hz_b, busy_b); end
        rst = 1'b1;
        issue_valid = 1'b1; issue_rd = 5'd6;
        tick();
        rst = 1'b0;
        idle();
        #1;
        checks++;
        if (hz_b !== 2'b00 || hz_n !== 2'b00 || busy_b !== 1'b0 || busy_n !== 1'b0) begin
            errors++; $display("FAIL midrst_sb: hazard %b/%b busy %b/%b exp 0", hz_b, hz_n, busy_b, busy_n);
        end
        set_read(5'd25, 5'd15);
        #1;
        checks++;
        if (rd_b !== 64'd0 || rd_n !== 64'd0) begin errors++; $display("FAIL midrst_data: got %h/%h exp 0", rd_b, rd_n); end
    endtask

    task automatic test_back_to_back();
        regwrite = 1'b1; writereg = 5'd1; writedata = 32'hA5A5_0001;
        tick();
        writereg = 5'd2; writedata = 32'h5A5A_0002;
        set_read(5'd2, 5'd1);
        #1;
        checks++;
        if (rd_b !== {32'h5A5A_0002, 32'hA5A5_0001}) begin errors++; $display("FAIL b2b_bypass: got %h exp %h", rd_b, {32'h5A5A_0002, 32'hA5A5_0001}); end
        checks++;
        if (rd_n[31:0] !== 32'hA5A5_0001 || rd_n[63:32] !== 32'd0) begin errors++; $display("FAIL b2b_nobypass: got %h", rd_n); end
        tick();
        idle();
        #1;
        checks++;
        if (rd_n !== {32'h5A5A_0002, 32'hA5A5_0001}) begin errors++; $display("FAIL b2b_array: got %h exp %h", rd_n, {32'h5A5A_0002, 32'hA5A5_0001}); end
    endtask

    initial begin
        rst = 1'b0;
        readreg = '0;
        idle();
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_simultaneous();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
